// File: rtl/fifo_burst_pkg.sv
// rtl/fifo_burst_pkg.sv - shared types and constants for the fifo burst drain
package fifo_burst_pkg;
  typedef enum logic [1:0] {DRAIN_IDLE, DRAIN_STREAM, DRAIN_DRAIN} drainState_t;

  localparam int BURSTCOUNTBITS = 16;

  typedef struct packed {
    logic valid;
    logic full;
  } fillStatus_t;
endpackage

// File: rtl/fifoConnect.sv
// rtl/fifoConnect.sv - connection bundle between the fifo core and its clients
interface fifoConnect #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  import fifo_burst_pkg::*;

  localparam int FILLBITS = $clog2(DEPTH + 1);

  logic                read;
  logic                write;
  logic [WIDTH-1:0]    datain;
  logic [WIDTH-1:0]    dataout;
  logic [FILLBITS-1:0] fillLevel;
  fillStatus_t         fillStatus;

  modport reader (output read, output write, output datain,
                  input dataout, input fillLevel, input fillStatus);
  modport core   (input read, input write, input datain,
                  output dataout, output fillLevel, output fillStatus);
endinterface

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry valid/ready output register
// Holds its payload stable while the sink stalls; reloads in the same cycle it drains.
module stream_out_reg
  import fifo_burst_pkg::*;
#(
  parameter int PW = 34
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_data,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);
  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - pops the fifo and re-emits words as framed bursts
// Full bursts start at BURST buffered words; a short flush follows TIMEOUT idle cycles.
module fifo_burst_drain
  import fifo_burst_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int BURST   = 8,
  parameter int TIMEOUT = 64,
  localparam int FILLBITS = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  fifoConnect.reader                link,
  output logic [WIDTH-1:0]          m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_first,
  output logic                      m_last,
  output logic [FILLBITS-1:0]       burst_len,
  output logic                      flush_pulse,
  output logic [BURSTCOUNTBITS-1:0] burst_count
);
  localparam int TIMERBITS = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TIMERBITS-1:0] TIMER_MAX = TIMERBITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [FILLBITS-1:0]  BURST_LEN = FILLBITS'(BURST);

  if (BURST < 1 || BURST > DEPTH) begin : g_bad_burst
    $error("fifo_burst_drain: BURST must satisfy 1 <= BURST <= DEPTH");
  end

  drainState_t               state_q, state_d;
  logic [FILLBITS-1:0]       remaining_q, remaining_d;
  logic [FILLBITS-1:0]       popped_q, popped_d;
  logic [TIMERBITS-1:0]      timer_q, timer_d;
  logic [FILLBITS-1:0]       burst_len_q, burst_len_d;
  logic                      flush_pulse_q, flush_pulse_d;
  logic [BURSTCOUNTBITS-1:0] burst_count_q, burst_count_d;

  logic             rd;
  logic             out_in_ready;
  logic [WIDTH+1:0] out_payload;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    popped_d      = popped_q;
    timer_d       = timer_q;
    burst_len_d   = burst_len_q;
    flush_pulse_d = 1'b0;
    burst_count_d = burst_count_q;
    rd            = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (enable && link.fillLevel >= BURST_LEN) begin
          state_d     = DRAIN_STREAM;
          burst_len_d = BURST_LEN;
          remaining_d = BURST_LEN;
          popped_d    = '0;
          timer_d     = '0;
        end else if (enable && TIMEOUT != 0 && timer_q == TIMER_MAX && link.fillLevel != '0) begin
          state_d       = DRAIN_STREAM;
          burst_len_d   = link.fillLevel;
          remaining_d   = link.fillLevel;
          popped_d      = '0;
          timer_d       = '0;
          flush_pulse_d = 1'b1;
        end else if (link.fillLevel == '0 || link.fillLevel >= BURST_LEN) begin
          timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      DRAIN_STREAM: begin
        // Pop only when the output register can take the word this cycle.
        rd = link.fillStatus.valid && remaining_q != '0 && out_in_ready;
        if (rd) begin
          remaining_d = remaining_q - 1'b1;
          popped_d    = popped_q + 1'b1;
          if (remaining_q == FILLBITS'(1)) state_d = DRAIN_DRAIN;
        end
      end
      DRAIN_DRAIN: begin
        if (m_valid && m_ready && m_last) begin
          burst_count_d = burst_count_q + 1'b1;
          state_d       = DRAIN_IDLE;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= DRAIN_IDLE;
      remaining_q   <= '0;
      popped_q      <= '0;
      timer_q       <= '0;
      burst_len_q   <= '0;
      flush_pulse_q <= 1'b0;
      burst_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      popped_q      <= popped_d;
      timer_q       <= timer_d;
      burst_len_q   <= burst_len_d;
      flush_pulse_q <= flush_pulse_d;
      burst_count_q <= burst_count_d;
    end
  end

  stream_out_reg #(.PW(WIDTH + 2)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (rd),
    .load_data ({popped_q == '0, remaining_q == FILLBITS'(1), link.dataout}),
    .out_ready (m_ready),
    .in_ready  (out_in_ready),
    .out_valid (m_valid),
    .out_data  (out_payload)
  );

  assign m_first     = out_payload[WIDTH+1];
  assign m_last      = out_payload[WIDTH];
  assign m_data      = out_payload[WIDTH-1:0];
  assign burst_len   = burst_len_q;
  assign flush_pulse = flush_pulse_q;
  assign burst_count = burst_count_q;

  assign link.read   = rd;
  assign link.write  = 1'b0;
  assign link.datain = '0;
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - self-checking bench for fifo_burst_drain
module tb_fifo_burst_drain;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_valid, m_first, m_last, flush_pulse;
  logic [5:0]  burst_len;
  logic [15:0] burst_count;

  fifoConnect #(.WIDTH(32), .DEPTH(32)) link_if ();

  fifo_burst_drain #(.WIDTH(32), .DEPTH(32), .BURST(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .link(link_if),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_first(m_first), .m_last(m_last), .burst_len(burst_len),
    .flush_pulse(flush_pulse), .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural fifo core: first-word-fall-through, optional output bubbles.
  logic [31:0] mem [64];
  logic [31:0] push_data [8];
  int push_n = 0;
  int wr_ptr, rd_ptr, fill;
  bit hold_en = 0;
  logic hold_out;

  always @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
    end else begin
      if (link_if.read) rd_ptr <= rd_ptr + 1;
      for (int i = 0; i < push_n; i++) mem[(wr_ptr + i) % 64] <= push_data[i];
      wr_ptr <= wr_ptr + push_n;
    end
  end

  always_comb begin
    fill                      = wr_ptr - rd_ptr;
    hold_out                  = hold_en && (cyc % 3 == 0);
    link_if.dataout           = mem[rd_ptr % 64];
    link_if.fillLevel         = fill[5:0];
    link_if.fillStatus.valid  = (fill != 0) && !hold_out;
    link_if.fillStatus.full   = (fill == 32);
  end

  int ready_mode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Capture of transfers and protocol observations.
  logic [31:0] cap_data [$];
  bit          cap_first [$];
  bit          cap_last [$];
  int          cap_len [$];
  int          flush_cyc [$];
  int          viol = 0, read_cnt = 0, gaps = 0;
  bit          stall_prev = 0, in_burst = 0;
  logic [31:0] prev_data;
  logic        prev_first, prev_last;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
      in_burst   = 0;
    end else begin
      if (link_if.read && (!link_if.fillStatus.valid || (m_valid && !m_ready))) viol++;
      if (link_if.read) read_cnt++;
      if (stall_prev && (!m_valid || m_data !== prev_data || m_first !== prev_first || m_last !== prev_last)) viol++;
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_first = m_first;
      prev_last  = m_last;
      if (flush_pulse) flush_cyc.push_back(cyc);
      if (in_burst && !m_valid) gaps++;
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data);
        cap_first.push_back(m_first);
        cap_last.push_back(m_last);
        cap_len.push_back(int'(burst_len));
        if (m_first) in_burst = 1;
        if (m_last) in_burst = 0;
      end
    end
  end

  // Reference model: words in push order, framed by the expected burst lengths.
  logic [31:0] exp_data [$];
  int          exp_lens [$];
  bit          exp_first [$];
  bit          exp_last [$];
  int          exp_blen [$];
  int          exp_bursts = 0;
  int          last_push_cyc = 0;

  function automatic void build_expected();
    exp_first.delete(); exp_last.delete(); exp_blen.delete();
    foreach (exp_lens[b])
      for (int k = 0; k < exp_lens[b]; k++) begin
        exp_first.push_back(k == 0);
        exp_last.push_back(k == exp_lens[b] - 1);
        exp_blen.push_back(exp_lens[b]);
      end
  endfunction

  task automatic clear_all();
    cap_data.delete(); cap_first.delete(); cap_last.delete(); cap_len.delete();
    flush_cyc.delete(); exp_data.delete(); exp_lens.delete();
    viol = 0; read_cnt = 0; gaps = 0;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      push_data[i] = $urandom;
      exp_data.push_back(push_data[i]);
    end
    push_n = n;
    @(posedge clk); #1;
    push_n = 0;
    last_push_cyc = cyc;
  endtask

  task automatic wait_words(input int n, input int budget, output bit timed_out);
    int c = 0;
    while (cap_data.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    timed_out = (cap_data.size() < n);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else passed++;
    total++; if (m_first !== 1'b0 || m_last !== 1'b0) $display("FAIL reset_flags: got first=%b last=%b want 0/0", m_first, m_last); else passed++;
    total++; if (m_data !== 32'h0) $display("FAIL reset_m_data: got %h want 0", m_data); else passed++;
    total++; if (burst_len !== 6'd0) $display("FAIL reset_burst_len: got %0d want 0", burst_len); else passed++;
    total++; if (flush_pulse !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush_pulse); else passed++;
    total++; if (burst_count !== 16'd0) $display("FAIL reset_burst_count: got %0d want 0", burst_count); else passed++;
    total++; if (link_if.read !== 1'b0 || link_if.write !== 1'b0 || link_if.datain !== 32'h0)
      $display("FAIL reset_link: got read=%b write=%b datain=%h want 0/0/0", link_if.read, link_if.write, link_if.datain); else passed++;
    reset = 1'b0;
    exp_bursts = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_two_bursts();
    bit to;
    clear_all(); ready_mode = 0;
    push(8); push(8);
    exp_lens = '{8, 8}; exp_bursts += 2;
    wait_words(16, 200, to);
    build_expected();
    total++; if (to || cap_data.size() != exp_data.size())
      $display("FAIL two_bursts_count: got %0d words want %0d", cap_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_data[i] || cap_first[i] !== exp_first[i] || cap_last[i] !== exp_last[i] || cap_len[i] != exp_blen[i])
        $display("FAIL two_bursts_word%0d: got %h f=%0b l=%0b len=%0d want %h f=%0b l=%0b len=%0d", i,
                 cap_data[i], cap_first[i], cap_last[i], cap_len[i], exp_data[i], exp_first[i], exp_last[i], exp_blen[i]);
      else passed++;
    end
    total++; if (burst_count !== 16'(exp_bursts)) $display("FAIL two_bursts_burst_count: got %0d want %0d", burst_count, exp_bursts); else passed++;
    total++; if (burst_len !== 6'd8) $display("FAIL two_bursts_burst_len: got %0d want 8", burst_len); else passed++;
    total++; if (flush_cyc.size() != 0) $display("FAIL two_bursts_flush: got %0d pulses want 0", flush_cyc.size()); else passed++;
  endtask

  task automatic test_flush();
    bit to;
    int want_cyc;
    clear_all(); ready_mode = 0;
    push(3);
    want_cyc = last_push_cyc + TIMEOUT;
    exp_lens = '{3}; exp_bursts += 1;
    wait_words(3, 200, to);
    build_expected();
    total++; if (flush_cyc.size() != 1 || flush_cyc[0] != want_cyc)
      $display("FAIL flush_timing: got %0d pulses first at %0d want 1 at %0d", flush_cyc.size(),
               (flush_cyc.size() > 0) ? flush_cyc[0] : -1, want_cyc); else passed++;
    total++; if (to || cap_data.size() != exp_data.size())
      $display("FAIL flush_count: got %0d words want %0d", cap_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_data[i] || cap_first[i] !== exp_first[i] || cap_last[i] !== exp_last[i] || cap_len[i] != exp_blen[i])
        $display("FAIL flush_word%0d: got %h f=%0b l=%0b len=%0d want %h f=%0b l=%0b len=%0d", i,
                 cap_data[i], cap_first[i], cap_last[i], cap_len[i], exp_data[i], exp_first[i], exp_last[i], exp_blen[i]);
      else passed++;
    end
    total++; if (burst_count !== 16'(exp_bursts)) $display("FAIL flush_burst_count: got %0d want %0d", burst_count, exp_bursts); else passed++;
  endtask

  task automatic test_backpressure();
    bit to;
    clear_all(); ready_mode = 1;
    push(8);
    exp_lens = '{8}; exp_bursts += 1;
    wait_words(8, 200, to);
    ready_mode = 0;
    build_expected();
    total++; if (to || cap_data.size() != exp_data.size())
      $display("FAIL backpressure_count: got %0d words want %0d", cap_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_data[i] || cap_first[i] !== exp_first[i] || cap_last[i] !== exp_last[i])
        $display("FAIL backpressure_word%0d: got %h f=%0b l=%0b want %h f=%0b l=%0b", i,
                 cap_data[i], cap_first[i], cap_last[i], exp_data[i], exp_first[i], exp_last[i]);
      else passed++;
    end
    total++; if (viol != 0) $display("FAIL backpressure_protocol: got %0d stall/read violations want 0", viol); else passed++;
    total++; if (burst_count !== 16'(exp_bursts)) $display("FAIL backpressure_burst_count: got %0d want %0d", burst_count, exp_bursts); else passed++;
  endtask

  task automatic test_underrun();
    bit to;
    clear_all(); ready_mode = 0; hold_en = 1;
    push(5);
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      push(1);
      repeat (3) @(posedge clk);
      #1;
    end
    exp_lens = '{8}; exp_bursts += 1;
    wait_words(8, 200, to);
    hold_en = 0;
    build_expected();
    total++; if (to || cap_data.size() != exp_data.size())
      $display("FAIL underrun_count: got %0d words want %0d", cap_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_data[i] || cap_first[i] !== exp_first[i] || cap_last[i] !== exp_last[i])
        $display("FAIL underrun_word%0d: got %h f=%0b l=%0b want %h f=%0b l=%0b", i,
                 cap_data[i], cap_first[i], cap_last[i], exp_data[i], exp_first[i], exp_last[i]);
      else passed++;
    end
    total++; if (gaps == 0) $display("FAIL underrun_gaps: got %0d idle cycles inside burst want >0", gaps); else passed++;
    total++; if (viol != 0) $display("FAIL underrun_protocol: got %0d read violations want 0", viol); else passed++;
    total++; if (flush_cyc.size() != 0) $display("FAIL underrun_flush: got %0d pulses want 0", flush_cyc.size()); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    bit to;
    bit hit = 0;
    clear_all(); ready_mode = 0;
    push(8);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      if (m_valid && cap_data.size() == 3) hit = 1;
    end
    total++; if (!hit) $display("FAIL reset_mid_reach: got no 4th word want 4th word on output"); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (m_valid !== 1'b0) $display("FAIL reset_mid_valid: got %b want 0", m_valid); else passed++;
    total++; if (burst_count !== 16'd0) $display("FAIL reset_mid_count: got %0d want 0", burst_count); else passed++;
    reset = 1'b0;
    exp_bursts = 0;
    @(posedge clk); #1;
    clear_all();
    push(8);
    exp_lens = '{8}; exp_bursts += 1;
    wait_words(8, 200, to);
    build_expected();
    total++; if (to || cap_data.size() != exp_data.size())
      $display("FAIL reset_mid_refill_count: got %0d words want %0d", cap_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_data[i] || cap_first[i] !== exp_first[i] || cap_last[i] !== exp_last[i])
        $display("FAIL reset_mid_word%0d: got %h f=%0b l=%0b want %h f=%0b l=%0b", i,
                 cap_data[i], cap_first[i], cap_last[i], exp_data[i], exp_first[i], exp_last[i]);
      else passed++;
    end
    total++; if (burst_count !== 16'(exp_bursts)) $display("FAIL reset_mid_burst_count: got %0d want %0d", burst_count, exp_bursts); else passed++;
  endtask

  task automatic test_enable_gate();
    bit to;
    clear_all(); ready_mode = 0;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) push(8);
    repeat (100) @(posedge clk);
    #1;
    total++; if (read_cnt != 0 || cap_data.size() != 0)
      $display("FAIL enable_gate_idle: got %0d reads %0d words want 0/0", read_cnt, cap_data.size()); else passed++;
    total++; if (flush_cyc.size() != 0) $display("FAIL enable_gate_flush: got %0d pulses want 0", flush_cyc.size()); else passed++;
    enable = 1'b1; ready_mode = 2;
    exp_lens = '{8, 8, 8, 8}; exp_bursts += 4;
    wait_words(32, 1000, to);
    ready_mode = 0;
    build_expected();
    total++; if (to || cap_data.size() != exp_data.size())
      $display("FAIL enable_gate_count: got %0d words want %0d", cap_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_data[i] || cap_first[i] !== exp_first[i] || cap_last[i] !== exp_last[i] || cap_len[i] != exp_blen[i])
        $display("FAIL enable_gate_word%0d: got %h f=%0b l=%0b len=%0d want %h f=%0b l=%0b len=%0d", i,
                 cap_data[i], cap_first[i], cap_last[i], cap_len[i], exp_data[i], exp_first[i], exp_last[i], exp_blen[i]);
      else passed++;
    end
    total++; if (burst_count !== 16'(exp_bursts)) $display("FAIL enable_gate_burst_count: got %0d want %0d", burst_count, exp_bursts); else passed++;
    total++; if (fill != 0) $display("FAIL enable_gate_empty: got fill %0d want 0", fill); else passed++;
    total++; if (viol != 0) $display("FAIL enable_gate_protocol: got %0d violations want 0", viol); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    test_reset();
    test_two_bursts();
    test_flush();
    test_backpressure();
    test_underrun();
    test_reset_mid_burst();
    test_enable_gate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
